// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - registered ARM-subset control decode stage with multi-cycle MUL sequencer
module ctrl_decode_stage #(
    parameter int ALU_CMD_W   = 4,
    parameter int MUL_LATENCY = 3,
    parameter int CNT_W       = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_in,
    input  logic                   S,
    input  logic [1:0]             mode,
    input  logic [3:0]             opcode,
    input  logic                   stall_in,
    input  logic                   flush,
    output logic [ALU_CMD_W+4:0]   ctrl_out,
    output logic                   one_input,
    output logic                   valid_out,
    output logic                   busy
);

    localparam int CW = ALU_CMD_W + 5;
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]     ctrl_q, ctrl_d;
    logic              one_q, one_d;
    logic              valid_q, valid_d;

    logic [3:0]        cmd4;
    logic              mem_read, mem_write, wb_en, branch_en, status_en;
    logic [CW-1:0]     dec_word;
    logic              dec_one;
    logic              advance;

    // Instruction decode; status_en and one_input are derived from the base fields
    always_comb begin
        cmd4      = 4'b0000;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        wb_en     = 1'b0;
        branch_en = 1'b0;
        case (mode)
            2'b00: begin
                case (opcode)
                    4'b1101: begin cmd4 = 4'b0001; wb_en = 1'b1; end
                    4'b1111: begin cmd4 = 4'b1001; wb_en = 1'b1; end
                    4'b0100: begin cmd4 = 4'b0010; wb_en = 1'b1; end
                    4'b0101: begin cmd4 = 4'b0011; wb_en = 1'b1; end
                    4'b0010: begin cmd4 = 4'b0100; wb_en = 1'b1; end
                    4'b0110: begin cmd4 = 4'b0101; wb_en = 1'b1; end
                    4'b0000: begin cmd4 = 4'b0110; wb_en = 1'b1; end
                    4'b1100: begin cmd4 = 4'b0111; wb_en = 1'b1; end
                    4'b0001: begin cmd4 = 4'b1000; wb_en = 1'b1; end
                    4'b1010: cmd4 = 4'b0100;
                    4'b1000: cmd4 = 4'b0110;
                    default: cmd4 = 4'b0000;
                endcase
            end
            2'b01: begin
                cmd4      = 4'b0010;
                mem_read  = S;
                wb_en     = S;
                mem_write = ~S;
            end
            2'b10: begin
                branch_en = 1'b1;
            end
            default: begin
                cmd4  = 4'b1010;
                wb_en = 1'b1;
            end
        endcase
        status_en = branch_en ? 1'b0 : S;
        dec_one   = ~((cmd4 == 4'b0001) | (cmd4 == 4'b1001) | branch_en);
        dec_word  = {ALU_CMD_W'(cmd4), mem_read, mem_write, wb_en, branch_en, status_en};
    end

    assign busy    = (state_q == MUL_BUSY);
    assign advance = ~stall_in & ~busy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        one_d   = one_q;
        valid_d = valid_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            ctrl_d  = '0;
            one_d   = 1'b0;
            valid_d = 1'b0;
        end else if (state_q == MUL_BUSY) begin
            // Bubble downstream while the multiply drains, independent of stall_in
            ctrl_d  = '0;
            one_d   = 1'b0;
            valid_d = 1'b0;
            cnt_d   = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                state_d = IDLE;
            end
        end else if (advance && valid_in) begin
            ctrl_d  = dec_word;
            one_d   = dec_one;
            valid_d = 1'b1;
            if ((mode == 2'b11) && (MUL_LATENCY > 1)) begin
                state_d = MUL_BUSY;
                cnt_d   = MUL_CNT_INIT;
            end
        end else if (advance) begin
            ctrl_d  = '0;
            one_d   = 1'b0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            one_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            one_q   <= one_d;
            valid_q <= valid_d;
        end
    end

    assign ctrl_out  = ctrl_q;
    assign one_input = one_q;
    assign valid_out = valid_q;

endmodule
